// File: rtl/mem_pkg.sv
// Shared widths, read/write encodings and tag-table entry states for the
// L2 memory request port.
package mem_pkg;

    localparam int MEM_ADDR_W  = 26;
    localparam int MEM_DATA_W  = 128;
    localparam int MEM_L2TAG_W = 5;

    localparam logic [1:0] MEM_RW_READ  = 2'b00;
    localparam logic [1:0] MEM_RW_WRITE = 2'b01;

    typedef enum logic [1:0] {
        ENT_FREE    = 2'd0,
        ENT_PEND    = 2'd1,
        ENT_BACKOFF = 2'd2,
        ENT_WAIT    = 2'd3
    } ent_state_e;

endpackage

// File: rtl/mem_req_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest set bit.
module mem_req_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Initiator side of the L2 memory port: tag table of outstanding single-beat
// requests with NACK backoff/reissue and 1-cycle client completions.
module mem_requester #(
    parameter int MEM_ADDR_BITS  = mem_pkg::MEM_ADDR_W,
    parameter int MEM_DATA_BITS  = mem_pkg::MEM_DATA_W,
    parameter int MEM_L2TAG_BITS = mem_pkg::MEM_L2TAG_W,
    parameter int NTAGS          = 4,
    parameter int RETRY_DELAY    = 3,
    parameter int ID_W           = (NTAGS > 1) ? $clog2(NTAGS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cli_req_val,
    output logic                      cli_req_rdy,
    input  logic [1:0]                cli_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]  cli_req_addr,
    input  logic [MEM_DATA_BITS-1:0]  cli_req_data,
    output logic [ID_W-1:0]           cli_req_id,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [1:0]                mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic [MEM_DATA_BITS-1:0]  mem_req_data,
    output logic [MEM_L2TAG_BITS-1:0] mem_req_tag,
    input  logic                      mem_resp_val,
    input  logic                      mem_resp_nack,
    input  logic [MEM_L2TAG_BITS-1:0] mem_resp_tag,
    input  logic [MEM_DATA_BITS-1:0]  mem_resp_data,
    output logic                      cli_resp_val,
    output logic [ID_W-1:0]           cli_resp_id,
    output logic [MEM_DATA_BITS-1:0]  cli_resp_data,
    output logic                      err,
    output logic [2*NTAGS-1:0]        dbg_state
);
    import mem_pkg::*;

    // Handshakes: a transfer happens on the rising edge where val && rdy;
    // val never depends on rdy, and the responder side has no backpressure.

    localparam int CNT_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY + 1) : 1;

    ent_state_e               state_q [NTAGS];
    ent_state_e               state_d [NTAGS];
    logic [CNT_W-1:0]         cnt_q   [NTAGS];
    logic [CNT_W-1:0]         cnt_d   [NTAGS];
    logic [1:0]               rw_q    [NTAGS];
    logic [MEM_ADDR_BITS-1:0] addr_q  [NTAGS];
    logic [MEM_DATA_BITS-1:0] data_q  [NTAGS];

    logic [NTAGS-1:0] free_vec, pend_vec;
    logic             free_found, pend_found;
    logic [ID_W-1:0]  free_idx, pend_idx, resp_idx;
    logic             accept, issue, resp_in_range, resp_hit, resp_ack;

    always_comb begin
        free_vec  = '0;
        pend_vec  = '0;
        dbg_state = '0;
        for (int i = 0; i < NTAGS; i++) begin
            free_vec[i]        = (state_q[i] == ENT_FREE);
            pend_vec[i]        = (state_q[i] == ENT_PEND);
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    mem_req_prio_enc #(.N(NTAGS), .IDX_W(ID_W)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    mem_req_prio_enc #(.N(NTAGS), .IDX_W(ID_W)) u_pend_enc (
        .req   (pend_vec),
        .found (pend_found),
        .idx   (pend_idx)
    );

    assign cli_req_rdy  = reset && free_found;
    assign cli_req_id   = free_idx;
    assign mem_req_val  = pend_found;
    assign mem_req_rw   = rw_q[pend_idx];
    assign mem_req_addr = addr_q[pend_idx];
    assign mem_req_data = data_q[pend_idx];
    assign mem_req_tag  = MEM_L2TAG_BITS'(pend_idx);

    assign accept        = cli_req_val && cli_req_rdy;
    assign issue         = mem_req_val && mem_req_rdy;
    assign resp_in_range = int'(mem_resp_tag) < NTAGS;
    assign resp_idx      = mem_resp_tag[ID_W-1:0];
    assign resp_hit      = mem_resp_val && resp_in_range && (state_q[resp_idx] == ENT_WAIT);
    assign resp_ack      = resp_hit && !mem_resp_nack;

    // Accept, issue and response always target distinct entries (FREE, PEND,
    // WAIT respectively), so their updates never collide.
    always_comb begin
        for (int i = 0; i < NTAGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == ENT_BACKOFF) begin
                if (cnt_q[i] <= CNT_W'(1)) state_d[i] = ENT_PEND;
                else                       cnt_d[i]   = cnt_q[i] - CNT_W'(1);
            end
        end
        if (accept) state_d[free_idx] = ENT_PEND;
        if (issue)  state_d[pend_idx] = ENT_WAIT;
        if (resp_hit) begin
            if (!mem_resp_nack) begin
                state_d[resp_idx] = ENT_FREE;
            end else if (RETRY_DELAY == 0) begin
                state_d[resp_idx] = ENT_PEND;
            end else begin
                state_d[resp_idx] = ENT_BACKOFF;
                cnt_d[resp_idx]   = CNT_W'(RETRY_DELAY);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAGS; i++) begin
                state_q[i] <= ENT_FREE;
                cnt_q[i]   <= '0;
            end
            err           <= 1'b0;
            cli_resp_val  <= 1'b0;
            cli_resp_id   <= '0;
            cli_resp_data <= '0;
        end else begin
            for (int i = 0; i < NTAGS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            if (mem_resp_val && !resp_hit) err <= 1'b1;
            cli_resp_val <= resp_ack;
            if (resp_ack) begin
                cli_resp_id   <= resp_idx;
                cli_resp_data <= (rw_q[resp_idx] == MEM_RW_WRITE) ? '0 : mem_resp_data;
            end
        end
    end

    // Payload is only meaningful while the entry is not FREE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q[free_idx]   <= cli_req_rw;
            addr_q[free_idx] <= cli_req_addr;
            data_q[free_idx] <= cli_req_data;
        end
    end

endmodule
